seq_signed_multiplier: RTL and testbench

- Sequential signed multiplier for the ALU multiply operation of the single-cycle processor datapath.
- Multiplies two two's-complement WIDTH-bit operands with a radix-2 Booth (shift-add) algorithm, one partial product per clock.
- Returns the truncated WIDTH-bit result, which is the register-file write-back value, and the full 2*WIDTH-bit product.
- Uses a START/BUSY/DONE handshake so the control unit can stall while the operation runs.

---
 rtl/seq_signed_multiplier.sv | 99 +++++++++
 tb/tb_seq_signed_multiplier.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: radix-2 Booth multiplier, one partial product per clock.
// Returns the truncated WIDTH-bit result and the full signed 2*WIDTH-bit product.
`default_nettype none

module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [WIDTH-1:0]     DATA1,
  input  logic [WIDTH-1:0]     DATA2,
  output logic [WIDTH-1:0]     OUTPUT,
  output logic [2*WIDTH-1:0]   PRODUCT,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  logic [2*WIDTH:0]    acc;
  logic [WIDTH-1:0]    mcand;
  logic [CW-1:0]       count;

  logic [WIDTH:0]      upper_ext;
  logic [WIDTH:0]      mcand_ext;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH:0]    acc_next;

  // The add/subtract is one bit wider than the upper half so that the
  // most-negative multiplicand cannot overflow; that extra bit becomes the
  // new sign after the arithmetic shift.
  always_comb begin
    upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand[WIDTH-1], mcand};
    sum       = upper_ext;
    case (acc[1:0])
      2'b01:   sum = upper_ext + mcand_ext;
      2'b10:   sum = upper_ext - mcand_ext;
      default: sum = upper_ext;
    endcase
    acc_next = {sum, acc[WIDTH:1]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      OUTPUT  <= '0;
      PRODUCT <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          DONE <= 1'b0;
          if (START) begin
            mcand <= DATA1;
            acc   <= {{WIDTH{1'b0}}, DATA2, 1'b0};
            count <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            PRODUCT <= acc_next[2*WIDTH:1];
            OUTPUT  <= acc_next[WIDTH:1];
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= FINISH;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier: directed, handshake, reset and random cases
// with a queue-based scoreboard compared on every DONE pulse.
`default_nettype none

module tb_seq_signed_multiplier;

  localparam int W = 8;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             START = 1'b0;
  logic [W-1:0]     DATA1 = '0;
  logic [W-1:0]     DATA2 = '0;
  logic [W-1:0]     OUTPUT;
  logic [2*W-1:0]   PRODUCT;
  logic             BUSY;
  logic             DONE;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .OUTPUT  (OUTPUT),
    .PRODUCT (PRODUCT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Scoreboard: every DONE pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    logic [2*W-1:0] e;
    if (RESET && DONE) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("product", PRODUCT, e);
        check_eq("output", OUTPUT, e[W-1:0]);
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    DATA1 = a;
    DATA2 = b;
    START = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (DONE !== 1'b1 && n < 4 * W) begin
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[8];
  int   n;

  initial begin
    vecs[0] = '{8'd3,    8'd5,    16'h000F};
    vecs[1] = '{8'd0,    8'd0,    16'h0000};
    vecs[2] = '{8'd10,   8'hFB,   16'hFFCE};
    vecs[3] = '{8'hFD,   8'hFB,   16'h000F};
    vecs[4] = '{8'hF9,   8'd6,    16'hFFD6};
    vecs[5] = '{8'd100,  8'd3,    16'h012C};
    vecs[6] = '{8'h80,   8'h80,   16'h4000};
    vecs[7] = '{8'h80,   8'd1,    16'hFF80};

    // Reset held with START toggling
    #3 RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      START = ~START;
      DATA1 = 8'd7;
      DATA2 = 8'd9;
    end
    @(negedge CLK);
    START = 1'b0;
    check_eq("rst_output", OUTPUT, 0);
    check_eq("rst_product", PRODUCT, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    RESET = 1'b1;
    @(negedge CLK);

    // Directed operand pairs, including sign and boundary cases
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, 1'b1);
      check_eq("busy_after_start", BUSY, 1);
      wait_done(n);
      check_eq("latency", n, W);
      check_eq("plan_product", PRODUCT, vecs[i].p);
      check_eq("plan_output", OUTPUT, vecs[i].p[W-1:0]);
      @(negedge CLK);
      check_eq("done_pulse", DONE, 0);
      check_eq("busy_idle", BUSY, 0);
      check_eq("hold_product", PRODUCT, vecs[i].p);
    end

    // START and operand changes while busy are ignored
    launch(8'd20, 8'hFA, 1'b1);
    repeat (3) @(negedge CLK);
    DATA1 = 8'd7;
    DATA2 = 8'd7;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    DATA1 = 8'h55;
    DATA2 = 8'hAA;
    wait_done(n);
    check_eq("busy_start_latency", n + 4, W);
    @(negedge CLK);
    check_eq("no_restart_done", DONE, 0);
    check_eq("no_restart_busy", BUSY, 0);

    // Back-to-back: START on the DONE cycle
    launch(8'd5, 8'd7, 1'b1);
    wait_done(n);
    launch(8'hF7, 8'd11, 1'b1);
    check_eq("b2b_busy", BUSY, 1);
    wait_done(n);
    check_eq("b2b_latency", n, W);
    @(negedge CLK);

    // Reset in the middle of an operation aborts it
    launch(8'd9, 8'd9, 1'b0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check_eq("abort_busy", BUSY, 0);
    check_eq("abort_done", DONE, 0);
    check_eq("abort_output", OUTPUT, 0);
    check_eq("abort_product", PRODUCT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (W + 3) @(negedge CLK);
    check_eq("abort_idle_busy", BUSY, 0);
    check_eq("abort_idle_output", OUTPUT, 0);

    // Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      launch(W'($urandom), W'($urandom), 1'b1);
      wait_done(n);
      check_eq("rand_latency", n, W);
    end
    @(negedge CLK);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
